// File: rtl/key_scan_ctrl.sv
// TM1638 key-scan scheduler, serial debouncer and press/release event FIFO.
// Define KEY_SCAN_TIMEOUT_EN to abandon a scan request after SCAN_TIMEOUT cycles.
module key_scan_ctrl #(
  parameter int NUM_KEYS         = 8,
  parameter int SAMPLE_PERIOD    = 100000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int FIFO_DEPTH       = 4,
  parameter int SCAN_TIMEOUT     = 1000
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  output logic                        o_Scan_Req,
  input  logic                        i_Scan_Valid,
  input  logic [NUM_KEYS-1:0]         i_Scan_Keys,
  output logic [NUM_KEYS-1:0]         o_Keys_Stable,
  output logic                        o_Event_Valid,
  input  logic                        i_Event_Ready,
  output logic                        o_Event_Pressed,
  output logic [$clog2(NUM_KEYS)-1:0] o_Event_Key,
  output logic                        o_Overflow,
  output logic                        o_Timeout
);

  localparam int KW = $clog2(NUM_KEYS);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = KW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    PROCESS
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]       per_cnt;
  logic [KW-1:0]       idx;
  logic [NUM_KEYS-1:0] raw_q;
  logic [NUM_KEYS-1:0] stable;
  logic [3:0]          dcnt [NUM_KEYS];

  logic per_done;
  logic last_key;
  logic tmo;

  assign per_done = per_cnt == PW'(SAMPLE_PERIOD - 1);
  assign last_key = idx == KW'(NUM_KEYS - 1);

`ifdef KEY_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(SCAN_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          tmo_q;

  assign tmo       = tcnt == TW'(SCAN_TIMEOUT - 1);
  assign o_Timeout = tmo_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tcnt  <= '0;
      tmo_q <= 1'b0;
    end else begin
      tcnt  <= (state == REQ) ? tcnt + TW'(1) : '0;
      tmo_q <= (state == REQ) && !i_Scan_Valid && tmo;
    end
  end
`else
  assign tmo       = 1'b0;
  assign o_Timeout = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (per_done) state_nx = REQ;
      REQ: begin
        if (i_Scan_Valid) state_nx = PROCESS;
        else if (tmo)     state_nx = IDLE;
      end
      PROCESS: if (last_key) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign o_Scan_Req = state == REQ;

  // One counter/comparator shared by all keys, steered by idx.
  logic       raw_k;
  logic       differ;
  logic [3:0] inc;
  logic       flip;

  assign raw_k  = raw_q[idx];
  assign differ = raw_k ^ stable[idx];
  assign inc    = dcnt[idx] + 4'd1;
  assign flip   = (state == PROCESS) && differ
               && (inc == 4'(DEBOUNCE_SAMPLES));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      per_cnt <= '0;
      idx     <= '0;
      raw_q   <= '0;
      stable  <= '0;
      for (int i = 0; i < NUM_KEYS; i++) dcnt[i] <= '0;
    end else begin
      per_cnt <= (state == IDLE && !per_done) ? per_cnt + PW'(1) : '0;
      if (state == REQ && i_Scan_Valid) raw_q <= i_Scan_Keys;
      if (state == PROCESS) begin
        idx <= last_key ? '0 : idx + KW'(1);
        if (!differ) begin
          dcnt[idx] <= '0;
        end else if (flip) begin
          stable[idx] <= raw_k;
          dcnt[idx]   <= '0;
        end else begin
          dcnt[idx] <= inc;
        end
      end
    end
  end

  assign o_Keys_Stable = stable;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          full, pop, wr, ovf;

  assign full = cnt == CW'(FIFO_DEPTH);
  assign pop  = o_Event_Valid && i_Event_Ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr   = flip && (!full || pop);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= {raw_k, idx};
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      if (flip && full && !pop) ovf <= 1'b1;
      unique case ({wr, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign o_Event_Valid = cnt != '0;
  assign {o_Event_Pressed, o_Event_Key} = mem[rp];
  assign o_Overflow = ovf;

endmodule
